// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared key codes and FSM encodings for the keypad entry path
//
// Purpose : constants and state types shared by keypad_press_detect and
//           keypad_entry_ctrl (and any other keypad consumer).
// Contents: KEY_BKSP / KEY_ENTER key codes, press-FSM and entry-FSM state
//           enums, and a digit classifier.
package keypad_pkg;

  localparam logic [3:0] KEY_BKSP  = 4'hE;
  localparam logic [3:0] KEY_ENTER = 4'hF;

  typedef enum logic [1:0] {
    PD_IDLE       = 2'd0,
    PD_DB_PRESS   = 2'd1,
    PD_HELD       = 2'd2,
    PD_DB_RELEASE = 2'd3
  } press_state_t;

  typedef enum logic {
    ENT_EDIT  = 1'b0,
    ENT_OFFER = 1'b1
  } entry_state_t;

  // Codes below backspace (0x0-0xD) are all treated as entry digits.
  function automatic logic is_digit(input logic [3:0] code);
    return code < KEY_BKSP;
  endfunction

endpackage

// File: rtl/keypad_press_detect.sv
// rtl/keypad_press_detect.sv - debounced one-pulse-per-press key event generator
//
// Purpose : turns the scanner's level outputs into one key_event pulse per
//           accepted press, with the press code captured alongside.
// Macro   : KEYPAD_DEBOUNCE_EN - when defined, presses and releases must be
//           stable for DEBOUNCE_CYCLES samples; when undefined the debounce
//           states and counter are removed and the first sample is accepted.
// Ports   :
//   sys_clk         in   system clock, rising edge
//   sys_rst_n       in   asynchronous active-low reset
//   key_code[3:0]   in   decoded key value from the scanner
//   key_pressed     in   scanner "key is down" level
//   key_event       out  single-cycle pulse per accepted press
//   key_event_code  out  code of the last accepted press (held)
module keypad_press_detect
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic [3:0] key_code,
  input  logic       key_pressed,
  output logic       key_event,
  output logic [3:0] key_event_code
);

  press_state_t state;

`ifdef KEYPAD_DEBOUNCE_EN

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The counter value already holds this many stable samples before the
  // current one, so seeing it with a stable input completes the window.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= PD_IDLE;
      cnt            <= '0;
      key_event      <= 1'b0;
      key_event_code <= 4'h0;
    end else begin
      key_event <= 1'b0;
      case (state)
        PD_IDLE: begin
          if (key_pressed) begin
            state <= PD_DB_PRESS;
            cnt   <= CW'(1);
          end
        end
        PD_DB_PRESS: begin
          if (!key_pressed) begin
            state <= PD_IDLE;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state          <= PD_HELD;
            cnt            <= '0;
            key_event      <= 1'b1;
            key_event_code <= key_code;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        PD_HELD: begin
          if (!key_pressed) begin
            state <= PD_DB_RELEASE;
            cnt   <= CW'(1);
          end
        end
        PD_DB_RELEASE: begin
          // A bounce back to 1 means the key is still down; no new event.
          if (key_pressed) begin
            state <= PD_HELD;
            cnt   <= '0;
          end else if (cnt >= CNT_LAST) begin
            state <= PD_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= PD_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`else

  // The cycle count has no meaning without the debounce counter.
  localparam int db_cycles_unused = DEBOUNCE_CYCLES;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state          <= PD_IDLE;
      key_event      <= 1'b0;
      key_event_code <= 4'h0;
    end else begin
      key_event <= 1'b0;
      case (state)
        PD_IDLE: begin
          if (key_pressed) begin
            state          <= PD_HELD;
            key_event      <= 1'b1;
            key_event_code <= key_code;
          end
        end
        PD_HELD: begin
          if (!key_pressed) begin
            state <= PD_IDLE;
          end
        end
        default: begin
          state <= PD_IDLE;
        end
      endcase
    end
  end

`endif

endmodule

// File: rtl/keypad_entry_ctrl.sv
// rtl/keypad_entry_ctrl.sv - hex digit entry buffer with enter/backspace and valid/ready offer
//
// Purpose : assembles debounced key events into a multi-digit hex entry
//           (E = backspace, F = enter) and offers it over valid/ready.
// Macro   : KEYPAD_DEBOUNCE_EN - selects the debounced press detector
//           (see keypad_press_detect); undefined gives the bypass detector.
// Ports   :
//   sys_clk                  in   system clock, rising edge
//   sys_rst_n                in   asynchronous active-low reset
//   key_code[3:0]            in   decoded key value from the scanner
//   key_pressed              in   scanner "key is down" level
//   key_event                out  single-cycle pulse per accepted press
//   key_event_code[3:0]      out  code of the last accepted press
//   entry_value[4*DIGITS-1:0] out assembled entry, newest digit in [3:0]
//   entry_count[3:0]         out  digits currently held
//   entry_valid              out  entry offered to the consumer
//   entry_ready              in   consumer accepts the entry
module keypad_entry_ctrl
  import keypad_pkg::*;
#(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 2_000_000
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic [3:0]            key_code,
  input  logic                  key_pressed,
  output logic                  key_event,
  output logic [3:0]            key_event_code,
  output logic [4*DIGITS-1:0]   entry_value,
  output logic [3:0]            entry_count,
  output logic                  entry_valid,
  input  logic                  entry_ready
);

  localparam int VW = 4 * DIGITS;
  localparam logic [3:0] MAX_COUNT = 4'(DIGITS);

  entry_state_t state;

  keypad_press_detect #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_press_detect (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .key_code       (key_code),
    .key_pressed    (key_pressed),
    .key_event      (key_event),
    .key_event_code (key_event_code)
  );

  // Events are consumed only in EDIT; while offering, value and count are
  // frozen, so an event coinciding with the handshake is dropped as well.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state       <= ENT_EDIT;
      entry_value <= '0;
      entry_count <= 4'h0;
      entry_valid <= 1'b0;
    end else begin
      case (state)
        ENT_EDIT: begin
          if (key_event) begin
            if (is_digit(key_event_code)) begin
              if (entry_count < MAX_COUNT) begin
                entry_value <= (entry_value << 4) | VW'(key_event_code);
                entry_count <= entry_count + 4'h1;
              end
            end else if (key_event_code == KEY_BKSP) begin
              if (entry_count != 4'h0) begin
                entry_value <= entry_value >> 4;
                entry_count <= entry_count - 4'h1;
              end
            end else if (key_event_code == KEY_ENTER) begin
              if (entry_count != 4'h0) begin
                state       <= ENT_OFFER;
                entry_valid <= 1'b1;
              end
            end
          end
        end
        ENT_OFFER: begin
          if (entry_ready) begin
            state       <= ENT_EDIT;
            entry_valid <= 1'b0;
            entry_value <= '0;
            entry_count <= 4'h0;
          end
        end
        default: begin
          state       <= ENT_EDIT;
          entry_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// tb/tb_keypad_entry_ctrl.sv - self-checking bench for keypad_entry_ctrl
//
// Purpose : directed key sequences against a behavioural model of the
//           accepted-press and entry rules, checked every cycle, plus
//           literal expectations at key points.
// Macro   : KEYPAD_DEBOUNCE_EN - selects the stable-sample window the model
//           expects (DEBOUNCE_CYCLES when defined, 1 otherwise).
module tb_keypad_entry_ctrl;

  localparam int DIGITS = 4;
  localparam int DB     = 8;
`ifdef KEYPAD_DEBOUNCE_EN
  localparam int DEFF = DB;
`else
  localparam int DEFF = 1;
`endif
  localparam int GLITCH_REL = (DEFF - 1 < 3) ? DEFF - 1 : 3;

  logic                sys_clk = 1'b0;
  logic                sys_rst_n = 1'b0;
  logic [3:0]          key_code = 4'h0;
  logic                key_pressed = 1'b0;
  logic                entry_ready = 1'b0;
  logic                key_event;
  logic [3:0]          key_event_code;
  logic [4*DIGITS-1:0] entry_value;
  logic [3:0]          entry_count;
  logic                entry_valid;

  always #5 sys_clk = ~sys_clk;

  keypad_entry_ctrl #(
    .DIGITS          (DIGITS),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .key_code       (key_code),
    .key_pressed    (key_pressed),
    .key_event      (key_event),
    .key_event_code (key_event_code),
    .entry_value    (entry_value),
    .entry_count    (entry_count),
    .entry_valid    (entry_valid),
    .entry_ready    (entry_ready)
  );

  int n_vec = 0;
  int n_err = 0;
  int ev_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a key is accepted down/up once the last DEFF samples agree;
  // the entry is a queue of digits, oldest first.
  int         run_len;
  logic       run_val;
  bit         down;
  bit         m_ev;
  logic [3:0] m_code;
  logic [3:0] dq[$];
  bit         m_offer;

  task automatic model_reset();
    run_len = 0;
    run_val = 1'b0;
    down    = 1'b0;
    m_ev    = 1'b0;
    m_code  = 4'h0;
    dq.delete();
    m_offer = 1'b0;
  endtask

  function automatic logic [31:0] m_value();
    logic [31:0] v = 0;
    foreach (dq[i]) v = (v << 4) | 32'(dq[i]);
    return v;
  endfunction

  initial model_reset();

  always @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      model_reset();
    end else begin
      if (m_offer) begin
        if (entry_ready) begin
          m_offer = 1'b0;
          dq.delete();
        end
      end else if (m_ev) begin
        if (m_code <= 4'hD) begin
          if (dq.size() < DIGITS) dq.push_back(m_code);
        end else if (m_code == 4'hE) begin
          if (dq.size() > 0) void'(dq.pop_back());
        end else if (dq.size() > 0) begin
          m_offer = 1'b1;
        end
      end
      if (run_len > 0 && key_pressed == run_val) begin
        if (run_len < DEFF) run_len++;
      end else begin
        run_val = key_pressed;
        run_len = 1;
      end
      m_ev = 1'b0;
      if (!down && run_val && run_len >= DEFF) begin
        down   = 1'b1;
        m_ev   = 1'b1;
        m_code = key_code;
      end else if (down && !run_val && run_len >= DEFF) begin
        down = 1'b0;
      end
    end
  end

  always @(negedge sys_clk) begin
    if (!sys_rst_n) model_reset();
    check("key_event", 32'(key_event), 32'(m_ev));
    check("key_event_code", 32'(key_event_code), 32'(m_code));
    check("entry_value", 32'(entry_value), m_value());
    check("entry_count", 32'(entry_count), 32'(dq.size()));
    check("entry_valid", 32'(entry_valid), 32'(m_offer));
    if (key_event) ev_seen++;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic press(input logic [3:0] c);
    key_code    = c;
    key_pressed = 1'b1;
    cyc(DEFF + 2);
    key_pressed = 1'b0;
    cyc(DEFF + 2);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    cyc(3);
    check("rst_key_event", 32'(key_event), 0);
    check("rst_code", 32'(key_event_code), 0);
    check("rst_value", 32'(entry_value), 0);
    check("rst_count", 32'(entry_count), 0);
    check("rst_valid", 32'(entry_valid), 0);
    sys_rst_n = 1'b1;
    cyc(2);

    // Press latency and first digit
    key_code    = 4'h5;
    key_pressed = 1'b1;
    repeat (DEFF - 1) @(posedge sys_clk);
    #1 check("lat_early", 32'(key_event), 0);
    @(posedge sys_clk);
    #1 check("lat_event", 32'(key_event), 1);
    check("lat_code", 32'(key_event_code), 32'h5);
    @(posedge sys_clk);
    #1 check("lat_event_once", 32'(key_event), 0);
    check("lat_value", 32'(entry_value), 32'h0005);
    check("lat_count", 32'(entry_count), 1);
    @(negedge sys_clk);
    cyc(2);
    key_pressed = 1'b0;
    cyc(DEFF + 2);

    // Short press glitch
    e0          = ev_seen;
    key_code    = 4'h9;
    key_pressed = 1'b1;
    cyc(DEFF - 1);
    key_pressed = 1'b0;
    cyc(DEFF + 2);
    check("glitch_events", 32'(ev_seen - e0), 0);
    check("glitch_count", 32'(entry_count), 1);

    press(4'hE);
    check("clear_count", 32'(entry_count), 0);

    // Enter on empty buffer
    press(4'hF);
    check("empty_enter_valid", 32'(entry_valid), 0);

    // Entry then stalled offer
    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'hF);
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      check("offer_valid", 32'(entry_valid), 1);
      check("offer_value", 32'(entry_value), 32'h0123);
      check("offer_count", 32'(entry_count), 3);
    end

    // Digit during offer is discarded
    e0 = ev_seen;
    press(4'h7);
    check("offer_digit_event", 32'(ev_seen - e0), 1);
    check("offer_digit_value", 32'(entry_value), 32'h0123);

    // Handshake
    entry_ready = 1'b1;
    @(posedge sys_clk);
    #1 check("hs_valid", 32'(entry_valid), 0);
    check("hs_value", 32'(entry_value), 0);
    check("hs_count", 32'(entry_count), 0);
    @(negedge sys_clk);

    // Overflow and backspace, with ready held high while nothing is offered
    press(4'h1);
    press(4'h2);
    press(4'h3);
    press(4'h4);
    press(4'h5);
    check("ovf_value", 32'(entry_value), 32'h1234);
    check("ovf_count", 32'(entry_count), 4);
    press(4'hE);
    check("bksp_value", 32'(entry_value), 32'h0123);
    check("bksp_count", 32'(entry_count), 3);
    press(4'hE);
    press(4'hE);
    press(4'hE);
    press(4'hE);
    check("bksp_empty_value", 32'(entry_value), 0);
    check("bksp_empty_count", 32'(entry_count), 0);
    entry_ready = 1'b0;

    // Release bounce
    e0          = ev_seen;
    key_code    = 4'hA;
    key_pressed = 1'b1;
    cyc(DEFF + 2);
    key_pressed = 1'b0;
    cyc(GLITCH_REL);
    key_pressed = 1'b1;
    cyc(DEFF + 2);
    key_pressed = 1'b0;
    cyc(DEFF + 2);
    check("rel_bounce_events", 32'(ev_seen - e0), 1);
    check("rel_bounce_value", 32'(entry_value), 32'h000A);

    // Reset during offer
    press(4'hF);
    check("pre_rst_valid", 32'(entry_valid), 1);
    @(posedge sys_clk);
    #3 sys_rst_n = 1'b0;
    #1 check("arst_valid", 32'(entry_valid), 0);
    check("arst_value", 32'(entry_value), 0);
    check("arst_count", 32'(entry_count), 0);
    check("arst_code", 32'(key_event_code), 0);
    check("arst_event", 32'(key_event), 0);
    @(negedge sys_clk);
    cyc(2);
    sys_rst_n = 1'b1;
    cyc(3);
    check("post_rst_valid", 32'(entry_valid), 0);
    check("post_rst_count", 32'(entry_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
